// File: rtl/outputlogic.sv
// Output decoder for the multicycle 8-bit MIPS controller: maps the 4-bit state
// code to registered datapath control strobes, one clock of latency.
module outputlogic (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] state,
   output logic       memread,
   output logic       memwrite,
   output logic       alusrca,
   output logic       memtoreg,
   output logic       iord,
   output logic       regwrite,
   output logic       regdst,
   output logic [1:0] pcsrc,
   output logic [1:0] alusrcb,
   output logic [3:0] irwrite,
   output logic       pcwrite,
   output logic       branch,
   output logic [1:0] aluop
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH1  = 4'd1,
      S_FETCH2  = 4'd2,
      S_FETCH3  = 4'd3,
      S_FETCH4  = 4'd4,
      S_DECODE  = 4'd5,
      S_MEMADR  = 4'd6,
      S_LBRD    = 4'd7,
      S_LBWR    = 4'd8,
      S_SBWR    = 4'd9,
      S_RTYPEEX = 4'd10,
      S_RTYPEWR = 4'd11,
      S_BEQEX   = 4'd12,
      S_JEX     = 4'd13,
      S_ADDIWR  = 4'd14
   } state_e;

   logic       memread_d,  memread_q;
   logic       memwrite_d, memwrite_q;
   logic       alusrca_d,  alusrca_q;
   logic       memtoreg_d, memtoreg_q;
   logic       iord_d,     iord_q;
   logic       regwrite_d, regwrite_q;
   logic       regdst_d,   regdst_q;
   logic [1:0] pcsrc_d,    pcsrc_q;
   logic [1:0] alusrcb_d,  alusrcb_q;
   logic [3:0] irwrite_d,  irwrite_q;
   logic       pcwrite_d,  pcwrite_q;
   logic       branch_d,   branch_q;
   logic [1:0] aluop_d,    aluop_q;

   // Decode the presented state; unlisted, unused or unknown codes yield all zeros.
   always_comb begin
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      alusrca_d  = 1'b0;
      memtoreg_d = 1'b0;
      iord_d     = 1'b0;
      regwrite_d = 1'b0;
      regdst_d   = 1'b0;
      pcsrc_d    = 2'b00;
      alusrcb_d  = 2'b00;
      irwrite_d  = 4'b0000;
      pcwrite_d  = 1'b0;
      branch_d   = 1'b0;
      aluop_d    = 2'b00;
      case (state)
         S_FETCH1: begin
            memread_d = 1'b1; irwrite_d = 4'b0001; alusrcb_d = 2'b01; pcwrite_d = 1'b1;
         end
         S_FETCH2: begin
            memread_d = 1'b1; irwrite_d = 4'b0010; alusrcb_d = 2'b01; pcwrite_d = 1'b1;
         end
         S_FETCH3: begin
            memread_d = 1'b1; irwrite_d = 4'b0100; alusrcb_d = 2'b01; pcwrite_d = 1'b1;
         end
         S_FETCH4: begin
            memread_d = 1'b1; irwrite_d = 4'b1000; alusrcb_d = 2'b01; pcwrite_d = 1'b1;
         end
         S_DECODE:  alusrcb_d = 2'b11;
         S_MEMADR: begin
            alusrca_d = 1'b1; alusrcb_d = 2'b10;
         end
         S_LBRD: begin
            memread_d = 1'b1; iord_d = 1'b1;
         end
         S_LBWR: begin
            regwrite_d = 1'b1; memtoreg_d = 1'b1;
         end
         S_SBWR: begin
            memwrite_d = 1'b1; iord_d = 1'b1;
         end
         S_RTYPEEX: begin
            alusrca_d = 1'b1; aluop_d = 2'b10;
         end
         S_RTYPEWR: begin
            regdst_d = 1'b1; regwrite_d = 1'b1;
         end
         S_BEQEX: begin
            alusrca_d = 1'b1; aluop_d = 2'b01; branch_d = 1'b1; pcsrc_d = 2'b01;
         end
         S_JEX: begin
            pcwrite_d = 1'b1; pcsrc_d = 2'b10;
         end
         S_ADDIWR:  regwrite_d = 1'b1;
         default: begin
            memread_d = 1'b0;
         end
      endcase
   end

   // Output registers with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         alusrca_q  <= 1'b0;
         memtoreg_q <= 1'b0;
         iord_q     <= 1'b0;
         regwrite_q <= 1'b0;
         regdst_q   <= 1'b0;
         pcsrc_q    <= 2'b00;
         alusrcb_q  <= 2'b00;
         irwrite_q  <= 4'b0000;
         pcwrite_q  <= 1'b0;
         branch_q   <= 1'b0;
         aluop_q    <= 2'b00;
      end else begin
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
         alusrca_q  <= alusrca_d;
         memtoreg_q <= memtoreg_d;
         iord_q     <= iord_d;
         regwrite_q <= regwrite_d;
         regdst_q   <= regdst_d;
         pcsrc_q    <= pcsrc_d;
         alusrcb_q  <= alusrcb_d;
         irwrite_q  <= irwrite_d;
         pcwrite_q  <= pcwrite_d;
         branch_q   <= branch_d;
         aluop_q    <= aluop_d;
      end
   end

   assign memread  = memread_q;
   assign memwrite = memwrite_q;
   assign alusrca  = alusrca_q;
   assign memtoreg = memtoreg_q;
   assign iord     = iord_q;
   assign regwrite = regwrite_q;
   assign regdst   = regdst_q;
   assign pcsrc    = pcsrc_q;
   assign alusrcb  = alusrcb_q;
   assign irwrite  = irwrite_q;
   assign pcwrite  = pcwrite_q;
   assign branch   = branch_q;
   assign aluop    = aluop_q;

endmodule

// File: tb/tb_outputlogic.sv
// Self-checking bench for outputlogic: directed scenarios plus random state/reset
// traffic checked against a per-signal membership model.
module tb_outputlogic;

   logic       clk;
   logic       reset_n;
   logic [3:0] state;
   logic       memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst;
   logic [1:0] pcsrc, alusrcb, aluop;
   logic [3:0] irwrite;
   logic       pcwrite, branch;

   int pass_cnt  = 0;
   int total_cnt = 0;

   outputlogic dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .state    (state),
      .memread  (memread),
      .memwrite (memwrite),
      .alusrca  (alusrca),
      .memtoreg (memtoreg),
      .iord     (iord),
      .regwrite (regwrite),
      .regdst   (regdst),
      .pcsrc    (pcsrc),
      .alusrcb  (alusrcb),
      .irwrite  (irwrite),
      .pcwrite  (pcwrite),
      .branch   (branch),
      .aluop    (aluop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed view: memread memwrite alusrca memtoreg iord regwrite regdst pcsrc alusrcb irwrite pcwrite branch aluop
   logic [18:0] obs;
   assign obs = {memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst,
                 pcsrc, alusrcb, irwrite, pcwrite, branch, aluop};

   // Reference: each control is described by the set of states that raise it.
   function automatic logic [18:0] model(input logic [3:0] st, input logic rn);
      logic       mr, mw, asa, mtr, io, rw, rd, pw, br;
      logic [1:0] ps, asb, op;
      logic [3:0] ir;
      int s;
      if (!rn || $isunknown(st)) return 19'd0;
      s   = int'(st);
      mr  = (s inside {1, 2, 3, 4, 7});
      mw  = (s == 9);
      asa = (s inside {6, 10, 12});
      mtr = (s == 8);
      io  = (s inside {7, 9});
      rw  = (s inside {8, 11, 14});
      rd  = (s == 11);
      pw  = (s inside {1, 2, 3, 4, 13});
      br  = (s == 12);
      ps  = (s == 12) ? 2'b01 : (s == 13) ? 2'b10 : 2'b00;
      asb = (s >= 1 && s <= 4) ? 2'b01 : (s == 5) ? 2'b11 : (s == 6) ? 2'b10 : 2'b00;
      ir  = (s >= 1 && s <= 4) ? (4'b0001 << (s - 1)) : 4'b0000;
      op  = (s == 10) ? 2'b10 : (s == 12) ? 2'b01 : 2'b00;
      return {mr, mw, asa, mtr, io, rw, rd, ps, asb, ir, pw, br, op};
   endfunction

   // Present one state for one clock and leave outputs settled after the edge.
   task automatic apply(input logic [3:0] st, input logic rn);
      @(negedge clk);
      state   = st;
      reset_n = rn;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         apply(4'd1, 1'b0);
         total_cnt++;
         if (obs !== 19'd0) $display("FAIL reset cycle %0d: got %h want %h", i, obs, 19'd0);
         else pass_cnt++;
      end
   endtask

   task automatic test_fetch();
      logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
      for (int i = 0; i < 4; i++) begin
         apply(seq[i], 1'b1);
         total_cnt++;
         if (obs !== model(seq[i], 1'b1))
            $display("FAIL fetch state %0d: got %h want %h", seq[i], obs, model(seq[i], 1'b1));
         else pass_cnt++;
         if (i > 0) begin
            total_cnt++;
            if (irwrite !== (4'b0001 << (i - 1)) || alusrcb !== 2'b01 || memread !== 1'b1 || pcwrite !== 1'b1)
               $display("FAIL fetch fields state %0d: irwrite %b alusrcb %b memread %b pcwrite %b", i, irwrite, alusrcb, memread, pcwrite);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_memory();
      for (int s = 6; s <= 9; s++) begin
         apply(4'(s), 1'b1);
         total_cnt++;
         if (obs !== model(4'(s), 1'b1))
            $display("FAIL memory state %0d: got %h want %h", s, obs, model(4'(s), 1'b1));
         else pass_cnt++;
      end
      total_cnt++;
      if (memwrite !== 1'b1 || iord !== 1'b1 || memread !== 1'b0 || regwrite !== 1'b0)
         $display("FAIL sbwr fields: memwrite %b iord %b memread %b regwrite %b want 1 1 0 0", memwrite, iord, memread, regwrite);
      else pass_cnt++;
   endtask

   task automatic test_branch_jump();
      apply(4'd12, 1'b1);
      total_cnt++;
      if (alusrca !== 1'b1 || aluop !== 2'b01 || branch !== 1'b1 || pcsrc !== 2'b01 || pcwrite !== 1'b0)
         $display("FAIL beqex: alusrca %b aluop %b branch %b pcsrc %b pcwrite %b want 1 01 1 01 0", alusrca, aluop, branch, pcsrc, pcwrite);
      else pass_cnt++;
      apply(4'd13, 1'b1);
      total_cnt++;
      if (obs !== model(4'd13, 1'b1) || pcwrite !== 1'b1 || pcsrc !== 2'b10 || branch !== 1'b0)
         $display("FAIL jex: got %h want %h", obs, model(4'd13, 1'b1));
      else pass_cnt++;
   endtask

   task automatic test_sweep();
      for (int s = 0; s < 16; s++) begin
         apply(4'(s), 1'b1);
         total_cnt++;
         if (obs !== model(4'(s), 1'b1))
            $display("FAIL sweep state %0d: got %h want %h", s, obs, model(4'(s), 1'b1));
         else pass_cnt++;
         total_cnt++;
         if ($countones(irwrite) > 1 || (memread && memwrite) || (pcwrite && branch))
            $display("FAIL invariant state %0d: irwrite %b memread %b memwrite %b pcwrite %b branch %b",
                     s, irwrite, memread, memwrite, pcwrite, branch);
         else pass_cnt++;
      end
   endtask

   task automatic test_mid_reset();
      apply(4'd2, 1'b1);
      apply(4'd4, 1'b0);
      total_cnt++;
      if (obs !== 19'd0) $display("FAIL mid reset: got %h want %h", obs, 19'd0);
      else pass_cnt++;
      apply(4'd5, 1'b1);
      total_cnt++;
      if (obs !== model(4'd5, 1'b1) || alusrcb !== 2'b11)
         $display("FAIL after mid reset: got %h want %h", obs, model(4'd5, 1'b1));
      else pass_cnt++;
   endtask

   task automatic test_unknown_state();
      apply(4'd1, 1'b1);
      apply(4'bxxxx, 1'b1);
      total_cnt++;
      if (obs !== 19'd0) $display("FAIL unknown state: got %h want %h", obs, 19'd0);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [3:0] st;
      logic       rn;
      for (int i = 0; i < 300; i++) begin
         st = 4'($urandom_range(0, 15));
         rn = ($urandom_range(0, 9) != 0);
         apply(st, rn);
         total_cnt++;
         if (obs !== model(st, rn))
            $display("FAIL random %0d state %0d rst_n %b: got %h want %h", i, st, rn, obs, model(st, rn));
         else pass_cnt++;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      state   = 4'd1;
      test_reset();
      test_fetch();
      test_memory();
      test_branch_jump();
      test_sweep();
      test_mid_reset();
      test_unknown_state();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
